// File: rtl/tcp_tx.sv
// TCP transmit framer: emits a fixed 20-byte header built from a latched
// descriptor, then passes the payload stream through on a 16-bit bus.
module tcp_tx #(
    parameter int unsigned IS_10G   = 1,
    parameter int unsigned DATA_W   = 16,
    parameter logic [15:0] SRC_PORT = 16'd9000,
    parameter logic [15:0] DST_PORT = 16'd9000
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       head_v_i,
    output logic                       head_ready_o,
    input  logic                       head_nodata_i,
    input  logic [31:0]                seq_i,
    input  logic [31:0]                ack_i,
    input  logic [7:0]                 flag_i,
    input  logic [15:0]                win_i,
    input  logic [15:0]                csum_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    input  logic [$clog2(DATA_W/8):0]  len_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic                       ready_o,
    output logic                       valid_o,
    output logic                       start_o,
    output logic                       last_o,
    output logic [$clog2(DATA_W/8):0]  len_o,
    output logic [DATA_W-1:0]          data_o,
    input  logic                       ready_i
);

    localparam int unsigned LEN_W = $clog2(DATA_W / 8) + 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(9);

    if ((DATA_W != 16) || (IS_10G > 1)) begin : g_bad_param
        $error("tcp_tx: only DATA_W=16 and IS_10G in {0,1} are supported");
    end

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        HEAD = 3'b010,
        DATA = 3'b100
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               valid_nxt, start_nxt, last_nxt, head_ready_nxt;
    logic [LEN_W-1:0]   len_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic [DATA_W-1:0]  hdr_beat;
    logic               hdr_load;
    logic               advance, head_hs;

    logic [31:0] seq_q, ack_q;
    logic [7:0]  flag_q;
    logic [15:0] win_q, csum_q;
    logic        nodata_q;

    assign advance = ~valid_o | ready_i;
    assign head_hs = head_v_i & head_ready_o;
    assign ready_o = (state == DATA) & advance;

    // Header beat k=cnt; k0 is loaded directly at the descriptor handshake.
    always_comb begin
        hdr_beat = '0;
        case (cnt)
            4'd0:    hdr_beat = SRC_PORT;
            4'd1:    hdr_beat = DST_PORT;
            4'd2:    hdr_beat = seq_q[31:16];
            4'd3:    hdr_beat = seq_q[15:0];
            4'd4:    hdr_beat = ack_q[31:16];
            4'd5:    hdr_beat = ack_q[15:0];
            4'd6:    hdr_beat = {4'd5, 4'b0000, flag_q};
            4'd7:    hdr_beat = win_q;
            4'd8:    hdr_beat = csum_q;
            default: hdr_beat = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = valid_o;
        start_nxt = start_o;
        last_nxt  = last_o;
        len_nxt   = len_o;
        data_nxt  = data_o;
        hdr_load  = 1'b0;
        case (state)
            IDLE: begin
                if (head_hs) begin
                    hdr_load  = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    valid_nxt = 1'b1;
                    start_nxt = 1'b1;
                    last_nxt  = 1'b0;
                    len_nxt   = LEN_W'(2);
                    data_nxt  = SRC_PORT;
                    state_nxt = HEAD;
                end else if (advance) begin
                    valid_nxt = 1'b0;
                    start_nxt = 1'b0;
                    last_nxt  = 1'b0;
                end
            end
            HEAD: begin
                if (advance) begin
                    valid_nxt = 1'b1;
                    start_nxt = 1'b0;
                    last_nxt  = (cnt == LAST_HDR) & nodata_q;
                    len_nxt   = LEN_W'(2);
                    data_nxt  = hdr_beat;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (cnt == LAST_HDR) begin
                        state_nxt = nodata_q ? IDLE : DATA;
                    end
                end
            end
            DATA: begin
                if (advance) begin
                    if (valid_i) begin
                        valid_nxt = 1'b1;
                        start_nxt = 1'b0;
                        last_nxt  = last_i;
                        len_nxt   = len_i;
                        data_nxt  = data_i;
                        if (last_i) begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        valid_nxt = 1'b0;
                        start_nxt = 1'b0;
                        last_nxt  = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Open for a new descriptor only once the output bus has drained,
        // which forces one IDLE cycle between segments.
        head_ready_nxt = (state_nxt == IDLE) & ~valid_nxt;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state        <= IDLE;
            cnt          <= '0;
            valid_o      <= 1'b0;
            start_o      <= 1'b0;
            last_o       <= 1'b0;
            len_o        <= '0;
            data_o       <= '0;
            head_ready_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            valid_o      <= valid_nxt;
            start_o      <= start_nxt;
            last_o       <= last_nxt;
            len_o        <= len_nxt;
            data_o       <= data_nxt;
            head_ready_o <= head_ready_nxt;
        end
    end

    // Descriptor fields held for the duration of the header.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seq_q    <= '0;
            ack_q    <= '0;
            flag_q   <= '0;
            win_q    <= '0;
            csum_q   <= '0;
            nodata_q <= 1'b0;
        end else if (hdr_load) begin
            seq_q    <= seq_i;
            ack_q    <= ack_i;
            flag_q   <= flag_i;
            win_q    <= win_i;
            csum_q   <= csum_i;
            nodata_q <= head_nodata_i;
        end
    end

    a_len_legal: assert property (@(posedge clk) disable iff (!nreset)
        (valid_i && ready_o) |-> ((len_i == LEN_W'(2)) || (last_i && (len_i == LEN_W'(1)))));

endmodule

// File: tb/tb_tcp_tx.sv
// Scoreboard bench for tcp_tx: expected beats come from a byte-level model of
// the segment format; a monitor pops and compares every accepted output beat.
module tb_tcp_tx;

    localparam logic [15:0] SRC = 16'd9000;
    localparam logic [15:0] DST = 16'd9000;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  len;
        logic        start;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  len;
        logic        last;
        int          gap;
    } pl_t;

    logic        clk, nreset;
    logic        head_v_i, head_ready_o, head_nodata_i;
    logic [31:0] seq_i, ack_i;
    logic [7:0]  flag_i;
    logic [15:0] win_i, csum_i;
    logic        valid_i, last_i, ready_o;
    logic [1:0]  len_i;
    logic [15:0] data_i;
    logic        valid_o, start_o, last_o, ready_i;
    logic [1:0]  len_o;
    logic [15:0] data_o;

    tcp_tx dut (
        .clk          (clk),
        .nreset       (nreset),
        .head_v_i     (head_v_i),
        .head_ready_o (head_ready_o),
        .head_nodata_i(head_nodata_i),
        .seq_i        (seq_i),
        .ack_i        (ack_i),
        .flag_i       (flag_i),
        .win_i        (win_i),
        .csum_i       (csum_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .len_i        (len_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .start_o      (start_o),
        .last_o       (last_o),
        .len_o        (len_o),
        .data_o       (data_o),
        .ready_i      (ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t      exp_q[$];
    pl_t        pl_q[$];
    logic [7:0] seg_bytes[$];
    int         gap_mode = 0;
    int         rdy_mode = 0;
    int         stall_n  = 0;
    int         hs_cyc   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: scoreboard compare, stall stability, timing bookkeeping.
    int    beat_idx = 0, run = 0, last_cyc = 0, start_cyc = 0, start_gap = 0, hr_rise_cyc = 0;
    int    beat_cyc[64];
    int    gap_before[64];
    logic  prev_stall = 1'b0, prev_hr = 1'b0;
    beat_t snap, mon_cur, mon_exp;

    always @(negedge clk) begin
        if (!nreset) begin
            beat_idx   = 0;
            run        = 0;
            prev_stall = 1'b0;
            prev_hr    = 1'b0;
        end else begin
            mon_cur = '{data: data_o, len: len_o, start: start_o, last: last_o};
            if (prev_stall) check("hold_during_stall", {valid_o, mon_cur}, {1'b1, snap});
            if (head_ready_o && !prev_hr) hr_rise_cyc = cyc;
            prev_hr = head_ready_o;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got=%0h exp=none", mon_cur);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat", mon_cur, mon_exp);
                end
                if (beat_idx < 64) begin
                    beat_cyc[beat_idx]   = cyc;
                    gap_before[beat_idx] = run;
                end
                run = 0;
                if (start_o) begin
                    start_gap = cyc - last_cyc;
                    start_cyc = cyc;
                end
                if (last_o) begin
                    last_cyc = cyc;
                    beat_idx = 0;
                end else begin
                    beat_idx++;
                end
            end else if (!valid_o) begin
                run++;
            end
            prev_stall = valid_o && !ready_i;
            snap       = mon_cur;
        end
    end

    // Output backpressure: always ready, random, or a 2-cycle stall on header beat k3.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    if (valid_o && beat_idx == 3 && stall_n < 2) begin
                        ready_i = 1'b0;
                        stall_n++;
                    end else begin
                        ready_i = 1'b1;
                    end
                end
                default: ready_i = 1'b1;
            endcase
        end
    end

    // Payload driver: each queued beat waits its idle gap, then holds until consumed.
    logic pl_acc = 1'b0;
    logic have   = 1'b0;
    int   wait_n = 0;
    pl_t  cur_pl;
    always @(negedge clk) pl_acc = valid_i && ready_o;

    initial begin
        valid_i = 1'b0;
        last_i  = 1'b0;
        len_i   = 2'd0;
        data_i  = 16'h0;
        forever begin
            @(posedge clk); #1;
            if (!nreset) begin
                valid_i = 1'b0;
                have    = 1'b0;
            end else begin
                if (pl_acc) begin
                    valid_i = 1'b0;
                    have    = 1'b0;
                end
                if (!have && pl_q.size() != 0) begin
                    cur_pl = pl_q.pop_front();
                    have   = 1'b1;
                    wait_n = cur_pl.gap;
                end
                if (have && !valid_i) begin
                    if (wait_n == 0) begin
                        valid_i = 1'b1;
                        data_i  = cur_pl.data;
                        len_i   = cur_pl.len;
                        last_i  = cur_pl.last;
                    end else begin
                        wait_n--;
                    end
                end
            end
        end
    end

    // Present a descriptor, wait for the handshake, and enqueue the expected segment.
    task automatic send_seg(input logic [31:0] seq, input logic [31:0] ack, input logic [7:0] flag,
                            input logic [15:0] win, input logic [15:0] csum);
        logic [7:0] hb[$];
        int   n, k, p;
        logic nodata;
        n      = seg_bytes.size();
        nodata = (n == 0);
        head_v_i = 1'b1;  head_nodata_i = nodata;
        seq_i = seq;  ack_i = ack;  flag_i = flag;  win_i = win;  csum_i = csum;
        k = 0;
        forever begin
            @(negedge clk);
            if (head_ready_o || k > 500) break;
            k++;
        end
        if (!head_ready_o) begin
            checks++;
            errors++;
            $display("FAIL head_handshake_timeout got=0 exp=1");
            head_v_i = 1'b0;
            seg_bytes.delete();
            return;
        end
        hs_cyc = cyc;
        hb = {SRC[15:8], SRC[7:0], DST[15:8], DST[7:0],
              seq[31:24], seq[23:16], seq[15:8], seq[7:0],
              ack[31:24], ack[23:16], ack[15:8], ack[7:0],
              8'h50, flag, win[15:8], win[7:0], csum[15:8], csum[7:0], 8'h00, 8'h00};
        for (int i = 0; i < 10; i++)
            exp_q.push_back('{data: {hb[2*i], hb[2*i+1]}, len: 2'd2,
                              start: (i == 0), last: (i == 9) && nodata});
        p = 0;
        for (int j = 0; j < n; j += 2) begin
            pl_t  b;
            logic two;
            two    = (j + 1 < n);
            b.data = two ? {seg_bytes[j], seg_bytes[j+1]} : {seg_bytes[j], 8'h00};
            b.len  = two ? 2'd2 : 2'd1;
            b.last = (j + 2 >= n);
            b.gap  = (gap_mode == 1) ? int'($urandom_range(0, 2)) :
                     (gap_mode == 2 && p == 1) ? 3 : 0;
            pl_q.push_back(b);
            exp_q.push_back('{data: b.data, len: b.len, start: 1'b0, last: b.last});
            p++;
        end
        @(posedge clk); #1;
        head_v_i = 1'b0;
        seg_bytes.delete();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || pl_q.size() != 0 || have) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got=%0d exp=0 beats outstanding", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nreset = 1'b0;
        head_v_i = 1'b0;  head_nodata_i = 1'b0;
        seq_i = '0;  ack_i = '0;  flag_i = '0;  win_i = '0;  csum_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", valid_o, 0);
        check("rst_start_o", start_o, 0);
        check("rst_last_o", last_o, 0);
        check("rst_len_o", len_o, 0);
        check("rst_data_o", data_o, 0);
        check("rst_head_ready_o", head_ready_o, 0);
        check("rst_ready_o", ready_o, 0);
        nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_head_ready_o", head_ready_o, 1);

        // Pure ACK with fixed fields and timing.
        send_seg(32'h01020304, 32'hA0B0C0D0, 8'h10, 16'hFFFF, 16'h1234);
        drain();
        check("ack_k0_latency", start_cyc, hs_cyc + 1);
        check("ack_k9_latency", last_cyc, hs_cyc + 10);
        check("ack_head_ready_back", hr_rise_cyc, hs_cyc + 11);

        // Five-byte payload.
        seg_bytes = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_seg($urandom(), $urandom(), 8'h18, 16'h4000, 16'hBEEF);
        drain();
        check("pl_first_beat_cyc", beat_cyc[10], hs_cyc + 11);
        check("pl_last_beat_cyc", beat_cyc[12], hs_cyc + 13);

        // Two-cycle stall on header beat k3.
        rdy_mode = 2;
        stall_n  = 0;
        send_seg(32'hCAFE0304, $urandom(), 8'h02, 16'h1000, 16'h0F0F);
        drain();
        rdy_mode = 0;
        check("stall_k3_accept_cyc", beat_cyc[3], hs_cyc + 6);
        check("stall_k9_accept_cyc", beat_cyc[9], hs_cyc + 12);

        // Three-cycle payload bubble before the second payload beat.
        gap_mode = 2;
        for (int i = 0; i < 8; i++) seg_bytes.push_back(8'(8'hA0 + i));
        send_seg($urandom(), $urandom(), 8'h18, $urandom(), $urandom());
        drain();
        gap_mode = 0;
        check("bubble_gap", gap_before[11], 3);
        check("bubble_no_gap_after", gap_before[12], 0);

        // Second descriptor presented while the first segment is still in DATA.
        for (int i = 0; i < 6; i++) seg_bytes.push_back(8'($urandom()));
        send_seg($urandom(), $urandom(), 8'h18, $urandom(), $urandom());
        for (int i = 0; i < 3; i++) seg_bytes.push_back(8'($urandom()));
        send_seg($urandom(), $urandom(), 8'h18, $urandom(), $urandom());
        drain();
        check("back_to_back_start_gap", start_gap, 2);

        // Asynchronous reset while k5 is on the output.
        send_seg(32'h11112222, 32'h3333ABCD, 8'h10, 16'h0100, 16'h5555);
        repeat (5) @(posedge clk);
        #1;
        check("pre_reset_k5", data_o, 16'hABCD);
        #2;
        nreset = 1'b0;
        #1;
        check("async_reset_valid_o", valid_o, 0);
        exp_q.delete();
        pl_q.delete();
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_seg($urandom(), $urandom(), 8'h11, $urandom(), $urandom());
        drain();
        check("post_reset_k0_latency", start_cyc, hs_cyc + 1);

        // Randomized segments with random backpressure and payload bubbles.
        rdy_mode = 1;
        gap_mode = 1;
        for (int s = 0; s < 25; s++) begin
            int n;
            n = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) seg_bytes.push_back(8'($urandom()));
            send_seg($urandom(), $urandom(), 8'($urandom()), 16'($urandom()), 16'($urandom()));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end
        drain();
        rdy_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcp_tx.md
Name: tcp_tx

Overview:
- Transmit-side TCP framer; counterpart to the TCP RX parser.
- Accepts a per-segment header descriptor from the TCP entry logic and a payload byte stream from the transport/application layer.
- Emits a 16-bit stream to the IP TX layer: a fixed 20-byte TCP header (no options) followed by the payload.
- The checksum is computed upstream. This block inserts it but does not calculate it.

Parameters:
- IS_10G, 1, kept for codebase symmetry; no effect on behaviour.
- DATA_W, 16, datapath width in bits; only 16 is supported.
- SRC_PORT, 16'd9000, local port placed in header bytes 0-1.
- DST_PORT, 16'd9000, remote port placed in header bytes 2-3.
- LEN_W, 2 (localparam, $clog2(DATA_W/8)+1), width of the valid-byte count; legal values 1..2.

Ports:
- clk  in  1  clock
- nreset  in  1  asynchronous active-low reset
- head_v_i  in  1  header descriptor valid
- head_ready_o  out  1  descriptor accepted when head_v_i & head_ready_o
- head_nodata_i  in  1  segment has no payload (pure ACK/SYN/FIN)
- seq_i  in  32  sequence number
- ack_i  in  32  acknowledgment number
- flag_i  in  8  {CWR,ECE,URG,ACK,PSH,RST,SYN,FIN}
- win_i  in  16  window
- csum_i  in  16  precomputed checksum
- valid_i  in  1  payload beat valid
- last_i  in  1  final payload beat
- len_i  in  2  valid bytes in beat (1 or 2; 1 only legal with last_i)
- data_i  in  16  payload; first byte on [15:8]
- ready_o  out  1  payload beat consumed when valid_i & ready_o
- valid_o  out  1  output beat valid
- start_o  out  1  first beat of segment
- last_o  out  1  final beat of segment
- len_o  out  2  valid bytes in output beat
- data_o  out  16  output data; first byte on [15:8]
- ready_i  in  1  IP layer accepts the output beat

Behaviour:
- Reset (async, nreset=0):
  - FSM goes to IDLE and the beat counter clears.
  - valid_o=0, start_o=0, last_o=0, len_o=0, data_o=0, head_ready_o=0 while held, ready_o=0.
  - Reset mid-segment drops the segment with no flush; after release the block is in IDLE.
- Output register:
  - Loads whenever ~valid_o | ready_i ("advance").
  - valid_o and its companions hold stable while valid_o & ~ready_i.
- FSM states: IDLE, HEAD, DATA (one-hot).
- IDLE:
  - head_ready_o=1.
  - On head_v_i, latch seq/ack/flag/win/csum/nodata, clear the beat counter and go to HEAD.
  - valid_o deasserts on the next advance.
- HEAD: on each advance, load header beat k=cnt, then cnt++. Beats, big-endian:
  - k0 SRC_PORT
  - k1 DST_PORT
  - k2 seq[31:16]
  - k3 seq[15:0]
  - k4 ack[31:16]
  - k5 ack[15:0]
  - k6 {4'd5, 4'b0, flag}
  - k7 win
  - k8 csum
  - k9 16'h0000
  - All header beats have len_o=2.
  - start_o=1 on k0 only.
  - After k9 loads: if nodata, last_o=1 on k9 and go to IDLE; otherwise go to DATA.
- Latency:
  - Descriptor handshake in cycle N gives k0 on valid_o in cycle N+1.
  - With ready_i held high, k9 appears at N+10 and the first payload beat at N+11.
- DATA:
  - ready_o = fsm_data & (~valid_o | ready_i).
  - An accepted payload beat loads data_o/len_o/last_o=last_i on the same edge (one-cycle pass-through).
  - Accepting last_i moves the FSM to IDLE.
  - If valid_i=0 in DATA, valid_o drops to 0 after the current beat is accepted (bubbles are allowed).
- head_ready_o is 0 in HEAD and DATA. A descriptor presented mid-segment waits.
- Back-to-back segments: the IDLE cycle after last_o is mandatory, so there is a one-cycle minimum gap before the next k0.
- Counter is 4 bits and saturates only via the state change; it never wraps within HEAD.
- Illegal len_i=1 without last_i is a formal assertion (sva). Behaviour is otherwise undefined.

Test Plan:
- Pure ACK: head_v with seq=32'h01020304, ack=32'hA0B0C0D0, flag=8'h10, win=16'hFFFF, csum=16'h1234, nodata=1, ready_i=1 -> 10 beats 2328,2328,0102,0304,A0B0,C0D0,5010,FFFF,1234,0000; start_o on beat 0, last_o on beat 9, head_ready_o back to 1 at N+11.
- Payload of 5 bytes (beats 1122, 3344, 55 with len 1, last): header beats, then 1122(len2), 3344(len2), 5500(len1, last_o=1); ready_o high only during DATA.
- Backpressure: ready_i toggled 1,0,0,1 during header beat k3 -> data_o=0304 is held stable across the stall; no beat is duplicated or skipped; total is still 10 header beats.
- Payload bubble: valid_i low for 3 cycles mid-payload -> valid_o low for 3 cycles, no spurious last_o, and the stream resumes in order.
- Descriptor during DATA: head_v_i asserted mid-payload -> head_ready_o=0 until IDLE; the second segment's start_o appears exactly 2 cycles after the first segment's last_o with ready_i=1.
- Async reset asserted at header beat k5 -> valid_o=0 immediately; after release a new descriptor produces a clean k0 with start_o=1.
